// File: rtl/cpu_wb_pkg.sv
// ---------------------------------------------------------------------------
// cpu_wb_pkg
// Shared types for the CPU write-back stage: opcode encodings, write-data
// source selector and the slot FSM state encoding.
// ---------------------------------------------------------------------------
package cpu_wb_pkg;

   // Opcode field i_instr[3:0]; enum members double as the OP_* constants.
   typedef enum logic [3:0] {
      OP_MV   = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_LD   = 4'd5,
      OP_MVHI = 4'd6,
      OP_JMP  = 4'd8,
      OP_JZ   = 4'd9,
      OP_JNZ  = 4'd10,
      OP_CALL = 4'd12
   } opcode_e;

   // Source of the register-file write data.
   typedef enum logic [2:0] {
      WS_NONE = 3'd0,
      WS_RY   = 3'd1,
      WS_IMM  = 3'd2,
      WS_ALU  = 3'd3,
      WS_MEM  = 3'd4,
      WS_MVHI = 3'd5,
      WS_LINK = 3'd6
   } wsel_e;

   // Slot occupancy.
   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FULL     = 2'd1,
      WAIT_MEM = 2'd2
   } wb_state_e;

   // Width of the immediate byte placed on top by mvhi.
   localparam int MVHI_IMM_W = 8;

endpackage

// File: rtl/cpu_wb_decode.sv
// ---------------------------------------------------------------------------
// cpu_wb_decode
// Combinational write-back decode of one instruction.
// Ports:
//   instr  in   low RW+5 bits of the instruction (op, imm flag, Rx)
//   writes out  instruction writes the register file
//   wsel   out  write-data source
//   dest   out  destination register (Rx, or LINK_REG for call)
// ---------------------------------------------------------------------------
module cpu_wb_decode
   import cpu_wb_pkg::*;
#(
   parameter int RW       = 3,
   parameter int LINK_REG = 7
) (
   input  logic [RW+4:0] instr,
   output logic          writes,
   output wsel_e         wsel,
   output logic [RW-1:0] dest
);

   logic [3:0] op;
   logic       imm_sel;

   assign op      = instr[3:0];
   assign imm_sel = instr[4];

   // Opcode to write/source/destination; unknown and jump opcodes write nothing.
   always_comb begin
      writes = 1'b1;
      wsel   = WS_NONE;
      dest   = instr[5 +: RW];
      case (op)
         OP_MV:          wsel = imm_sel ? WS_IMM : WS_RY;
         OP_ADD, OP_SUB: wsel = WS_ALU;
         OP_LD:          wsel = WS_MEM;
         OP_MVHI:        wsel = WS_MVHI;
         OP_CALL: begin
            wsel = WS_LINK;
            dest = RW'(LINK_REG);
         end
         default:        writes = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_wb_stage.sv
// ---------------------------------------------------------------------------
// cpu_wb_stage
// One-entry register-file write-back stage. Captures an instruction from MEM
// on i_valid & o_ready, selects its write data at capture time, and retires it
// one cycle later. Loads wait in WAIT_MEM until i_mem_rvalid.
// Optional feature macro: WB_BYPASS_EN (registered bypass of last write).
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   i_valid / o_ready      upstream handshake
//   i_instr                op=[3:0], imm=[4], Rx=[5+:RW]
//   i_pc,i_alu,i_imm,
//   i_ry,i_rx              write-data candidates
//   i_mem_rvalid/rdata     load return
//   i_flush                kill non-load slot contents
//   rf_we/waddr/wdata      register-file write port
//   byp_valid/addr/data    bypass of previous cycle's write
// ---------------------------------------------------------------------------
module cpu_wb_stage
   import cpu_wb_pkg::*;
#(
   parameter int DW       = 16,
   parameter int NREG     = 8,
   parameter int LINK_REG = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [15:0]              i_instr,
   input  logic [DW-1:0]            i_pc,
   input  logic [DW-1:0]            i_alu,
   input  logic [DW-1:0]            i_imm,
   input  logic [DW-1:0]            i_ry,
   input  logic [DW-1:0]            i_rx,
   input  logic                     i_mem_rvalid,
   input  logic [DW-1:0]            i_mem_rdata,
   input  logic                     i_flush,
   output logic                     rf_we,
   output logic [$clog2(NREG)-1:0]  rf_waddr,
   output logic [DW-1:0]            rf_wdata,
   output logic                     byp_valid,
   output logic [$clog2(NREG)-1:0]  byp_addr,
   output logic [DW-1:0]            byp_data
);

   localparam int RW = $clog2(NREG);

   if (DW < 16 || NREG < 2 || NREG > 8 || (NREG & (NREG - 1)) != 0 ||
       LINK_REG >= NREG) begin : g_bad_params
      $error("cpu_wb_stage: illegal DW/NREG/LINK_REG");
   end

   wb_state_e      state, state_nxt;
   logic           slot_we;
   logic [RW-1:0]  slot_dest;
   logic [DW-1:0]  slot_data;

   logic           dec_writes;
   wsel_e          dec_wsel;
   logic [RW-1:0]  dec_dest;
   logic [DW-1:0]  cap_data;
   logic           ready;
   logic           capture;
   logic           we;
   logic           unused_inputs;

   // Only the low byte of i_imm and low DW-8 bits of i_rx reach mvhi data.
   assign unused_inputs = ^{i_instr[15:RW+5], i_rx[DW-1:DW-MVHI_IMM_W]};

   cpu_wb_decode #(
      .RW       (RW),
      .LINK_REG (LINK_REG)
   ) u_decode (
      .instr  (i_instr[RW+4:0]),
      .writes (dec_writes),
      .wsel   (dec_wsel),
      .dest   (dec_dest)
   );

   // Write data chosen at capture so the slot holds no raw operands.
   always_comb begin
      cap_data = '0;
      case (dec_wsel)
         WS_RY:   cap_data = i_ry;
         WS_IMM:  cap_data = i_imm;
         WS_ALU:  cap_data = i_alu;
         WS_MVHI: cap_data = {i_imm[MVHI_IMM_W-1:0], i_rx[DW-MVHI_IMM_W-1:0]};
         WS_LINK: cap_data = i_pc;
         default: cap_data = '0;
      endcase
   end

   // Handshake, retire and next-state logic of the slot FSM.
   always_comb begin
      ready     = 1'b1;
      we        = 1'b0;
      state_nxt = state;
      case (state)
         EMPTY:    ready = 1'b1;
         FULL: begin
            ready = ~i_flush;
            we    = slot_we & ~i_flush;
         end
         WAIT_MEM: begin
            ready = i_mem_rvalid;
            we    = i_mem_rvalid;
         end
         default:  ready = 1'b1;
      endcase

      // Flush beats a simultaneous valid: nothing new enters the slot.
      capture = i_valid & ready & ~i_flush;

      if (state == WAIT_MEM && !i_mem_rvalid) begin
         state_nxt = WAIT_MEM;
      end else if (capture) begin
         state_nxt = (dec_wsel == WS_MEM) ? WAIT_MEM : FULL;
      end else begin
         state_nxt = EMPTY;
      end
   end

   // Slot state and captured write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= EMPTY;
         slot_we   <= 1'b0;
         slot_dest <= '0;
         slot_data <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            slot_we   <= dec_writes;
            slot_dest <= dec_dest;
            slot_data <= cap_data;
         end else begin
            slot_we   <= slot_we;
         end
      end
   end

   assign o_ready  = ready;
   assign rf_we    = we;
   assign rf_waddr = we ? slot_dest : '0;
   assign rf_wdata = !we ? '0 : ((state == WAIT_MEM) ? i_mem_rdata : slot_data);

`ifdef WB_BYPASS_EN
   // Registered copy of the write just issued, for decode to forward.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byp_valid <= 1'b0;
         byp_addr  <= '0;
         byp_data  <= '0;
      end else begin
         byp_valid <= rf_we;
         byp_addr  <= rf_waddr;
         byp_data  <= rf_wdata;
      end
   end
`else
   assign byp_valid = 1'b0;
   assign byp_addr  = '0;
   assign byp_data  = '0;
`endif

endmodule
